// File: rtl/store_write_buffer.sv
// Commit-side store FIFO: buffers committed stores, drains them in order over a req/ack port,
// and forwards buffered data to loads. Optional store coalescing is enabled by WB_COALESCE_EN.
module store_write_buffer #(
   parameter int DEPTH = 8,
   parameter int PTR_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             commitWriteEnable,
   input  logic [31:0]      commitWriteAddr,
   input  logic [31:0]      commitWriteData,
   output logic             commitReady,
   output logic             memWriteEnable,
   output logic [31:0]      memWriteAddr,
   output logic [31:0]      memWriteData,
   input  logic             memWriteAck,
   input  logic [31:0]      loadQueryAddr,
   output logic             loadHit,
   output logic [31:0]      loadHitData,
   output logic [PTR_W:0]   bufCount,
   output logic             drained
);
   typedef enum logic {IDLE, REQ} state_t;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } entry_t;

   state_t                state;
   entry_t [DEPTH-1:0]    ent;
   logic   [DEPTH-1:0]    valid;
   logic   [PTR_W-1:0]    head, tail, head_n, wr_idx, coal_idx;
   logic   [PTR_W:0]      count_n;
   logic                  coal_hit, accept, alloc, pop;
   entry_t                nxt;

   // Walk entries oldest to youngest so the youngest match is the one left standing.
   always_comb begin : fwd
      logic [PTR_W-1:0] idx;
      idx         = '0;
      loadHit     = 1'b0;
      loadHitData = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (valid[idx] && ent[idx].addr == loadQueryAddr) begin
            loadHit     = 1'b1;
            loadHitData = ent[idx].data;
         end
      end
   end

`ifdef WB_COALESCE_EN
   // The head being presented to memory must stay stable, so it never takes a merge.
   always_comb begin : coal
      logic [PTR_W-1:0] idx;
      idx      = '0;
      coal_hit = 1'b0;
      coal_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if (valid[idx] && ent[idx].addr == commitWriteAddr &&
             !(state == REQ && idx == head)) begin
            coal_hit = 1'b1;
            coal_idx = idx;
         end
      end
   end
`else
   assign coal_hit = 1'b0;
   assign coal_idx = '0;
`endif

   assign commitReady = (bufCount < (PTR_W+1)'(DEPTH)) || coal_hit;
   assign drained     = (bufCount == '0) && (state == IDLE);
   assign accept      = commitWriteEnable && commitReady;
   assign alloc       = accept && !coal_hit;
   assign pop         = (state == REQ) && memWriteAck;
   assign head_n      = pop ? head + PTR_W'(1) : head;
   assign wr_idx      = coal_hit ? coal_idx : tail;
   // Bypass a store landing in the entry that becomes the presented head at this edge.
   assign nxt         = (accept && wr_idx == head_n) ? entry_t'({commitWriteAddr, commitWriteData})
                                                     : ent[head_n];

   always_comb begin
      count_n = bufCount;
      if (alloc && !pop)
         count_n = bufCount + (PTR_W+1)'(1);
      else if (!alloc && pop)
         count_n = bufCount - (PTR_W+1)'(1);
   end

   always_ff @(posedge clk) begin
      if (accept)
         ent[wr_idx] <= entry_t'({commitWriteAddr, commitWriteData});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         head           <= '0;
         tail           <= '0;
         bufCount       <= '0;
         valid          <= '0;
         memWriteEnable <= 1'b0;
         memWriteAddr   <= '0;
         memWriteData   <= '0;
      end else begin
         bufCount <= count_n;
         head     <= head_n;
         if (alloc) begin
            tail         <= tail + PTR_W'(1);
            valid[tail]  <= 1'b1;
         end
         if (pop)
            valid[head] <= 1'b0;
         case (state)
            IDLE: begin
               if (bufCount != '0) begin
                  state          <= REQ;
                  memWriteEnable <= 1'b1;
                  memWriteAddr   <= nxt.addr;
                  memWriteData   <= nxt.data;
               end
            end
            REQ: begin
               if (pop) begin
                  if (count_n != '0) begin
                     memWriteAddr <= nxt.addr;
                     memWriteData <= nxt.data;
                  end else begin
                     state          <= IDLE;
                     memWriteEnable <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: queue-based model checked every cycle plus directed literal checks.
// Follows WB_COALESCE_EN the same way the design does.
module tb_store_write_buffer;
   localparam int DEPTH = 8;
   localparam int PTR_W = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             commitWriteEnable;
   logic [31:0]      commitWriteAddr, commitWriteData;
   logic             commitReady;
   logic             memWriteEnable;
   logic [31:0]      memWriteAddr, memWriteData;
   logic             memWriteAck;
   logic [31:0]      loadQueryAddr;
   logic             loadHit;
   logic [31:0]      loadHitData;
   logic [PTR_W:0]   bufCount;
   logic             drained;

   store_write_buffer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
      .clk(clk), .rst(rst),
      .commitWriteEnable(commitWriteEnable), .commitWriteAddr(commitWriteAddr),
      .commitWriteData(commitWriteData), .commitReady(commitReady),
      .memWriteEnable(memWriteEnable), .memWriteAddr(memWriteAddr),
      .memWriteData(memWriteData), .memWriteAck(memWriteAck),
      .loadQueryAddr(loadQueryAddr), .loadHit(loadHit), .loadHitData(loadHitData),
      .bufCount(bufCount), .drained(drained)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
   ent_t q[$];
   ent_t wlog[$];
   bit   busy;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int coal_at(input logic [31:0] a);
`ifdef WB_COALESCE_EN
      for (int j = q.size() - 1; j >= (busy ? 1 : 0); j--)
         if (q[j].a == a) return j;
`endif
      return -1;
   endfunction

   function automatic bit ready_m(input logic [31:0] a);
      return (q.size() < DEPTH) || (coal_at(a) >= 0);
   endfunction

   function automatic logic [32:0] fwd_m(input logic [31:0] a);
      for (int j = q.size() - 1; j >= 0; j--)
         if (q[j].a == a) return {1'b1, q[j].d};
      return 33'd0;
   endfunction

   // Model: a queue of pending stores; busy means the oldest one is on the memory port.
   always @(posedge clk or posedge rst) begin
      int  pre;
      int  j;
      bit  pop;
      if (rst) begin
         q.delete();
         busy = 1'b0;
      end else begin
         pre = q.size();
         pop = busy && memWriteAck;
         if (commitWriteEnable && ready_m(commitWriteAddr)) begin
            j = coal_at(commitWriteAddr);
            if (j >= 0) q[j].d = commitWriteData;
            else        q.push_back('{commitWriteAddr, commitWriteData});
         end
         if (pop) q.delete(0);
         if (busy) busy = pop ? (q.size() > 0) : 1'b1;
         else      busy = (pre > 0);
      end
   end

   initial begin
      logic [32:0] f;
      forever begin
         @(negedge clk);
         #2;
         f = fwd_m(loadQueryAddr);
         chk("bufCount", 32'(bufCount), 32'(q.size()));
         chk("commitReady", 32'(commitReady), 32'(ready_m(commitWriteAddr)));
         chk("drained", 32'(drained), 32'(q.size() == 0 && !busy));
         chk("memWriteEnable", 32'(memWriteEnable), 32'(busy));
         if (busy && q.size() > 0) begin
            chk("memWriteAddr", memWriteAddr, q[0].a);
            chk("memWriteData", memWriteData, q[0].d);
         end
         chk("loadHit", 32'(loadHit), 32'(f[32]));
         chk("loadHitData", loadHitData, f[31:0]);
         if (!rst && memWriteEnable && memWriteAck)
            wlog.push_back('{memWriteAddr, memWriteData});
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic push_set(input logic [31:0] a, input logic [31:0] d);
      commitWriteEnable = 1'b1;
      commitWriteAddr   = a;
      commitWriteData   = d;
   endtask

   task automatic wait_drained(input int max);
      int k = 0;
      while (!drained && k < max) begin
         step();
         k++;
      end
      chk("drain_timeout", 32'(drained), 32'd1);
   endtask

   task automatic chk_log(input string name, input ent_t exp[$]);
      chk({name, "_count"}, 32'(wlog.size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < wlog.size(); i++) begin
         chk({name, "_addr"}, wlog[i].a, exp[i].a);
         chk({name, "_data"}, wlog[i].d, exp[i].d);
      end
   endtask

   initial begin
      ent_t exp[$];
      rst = 1'b1;
      commitWriteEnable = 1'b0;
      commitWriteAddr = '0;
      commitWriteData = '0;
      memWriteAck = 1'b0;
      loadQueryAddr = '0;
      #2;
      chk("rst_memWriteEnable", 32'(memWriteEnable), 32'd0);
      chk("rst_bufCount", 32'(bufCount), 32'd0);
      chk("rst_commitReady", 32'(commitReady), 32'd1);
      chk("rst_drained", 32'(drained), 32'd1);
      chk("rst_memWriteAddr", memWriteAddr, 32'd0);
      repeat (2) step();
      rst = 1'b0;
      step();

      // Single store with ack tied high; ack while idle must be harmless.
      memWriteAck = 1'b1;
      step();
      push_set(32'h10, 32'h55);
      step();
      commitWriteEnable = 1'b0;
      #3 chk("t2_bufCount", 32'(bufCount), 32'd1);
      chk("t2_mwe_early", 32'(memWriteEnable), 32'd0);
      step();
      #3 chk("t2_mwe", 32'(memWriteEnable), 32'd1);
      chk("t2_addr", memWriteAddr, 32'h10);
      chk("t2_data", memWriteData, 32'h55);
      step();
      #3 chk("t2_mwe_off", 32'(memWriteEnable), 32'd0);
      chk("t2_drained", 32'(drained), 32'd1);
      step();

      // Fill to full, reject while full (even alongside a pop), then retry.
      memWriteAck = 1'b0;
      wlog.delete();
      for (int i = 0; i < 8; i++) begin
         push_set(32'(i), 32'h100 + 32'(i));
         step();
      end
      push_set(32'd8, 32'h108);
      #3 chk("t3_full_count", 32'(bufCount), 32'd8);
      chk("t3_full_ready", 32'(commitReady), 32'd0);
      step();
      #3 chk("t3_ignored", 32'(bufCount), 32'd8);
      step();
      memWriteAck = 1'b1;
      #3 chk("t4_ready_during_pop", 32'(commitReady), 32'd0);
      step();
      memWriteAck = 1'b0;
      #3 chk("t4_after_pop_count", 32'(bufCount), 32'd7);
      chk("t4_after_pop_ready", 32'(commitReady), 32'd1);
      step();
      commitWriteEnable = 1'b0;
      #3 chk("t4_retry_count", 32'(bufCount), 32'd8);
      step();
      memWriteAck = 1'b1;
      wait_drained(40);
      exp.delete();
      for (int i = 0; i < 9; i++) exp.push_back('{32'(i), 32'h100 + 32'(i)});
      chk_log("t3_order", exp);

      // Forwarding: youngest store to an address wins; misses report zero.
      memWriteAck = 1'b0;
      wlog.delete();
      push_set(32'h20, 32'd1);
      step();
      push_set(32'h20, 32'd2);
      step();
      commitWriteEnable = 1'b0;
      loadQueryAddr = 32'h20;
      #3 chk("t5_hit", 32'(loadHit), 32'd1);
      chk("t5_hit_data", loadHitData, 32'd2);
      loadQueryAddr = 32'h24;
      #1 chk("t5_miss", 32'(loadHit), 32'd0);
      chk("t5_miss_data", loadHitData, 32'd0);
      step();
      memWriteAck = 1'b1;
      wait_drained(20);
      exp.delete();
`ifndef WB_COALESCE_EN
      exp.push_back('{32'h20, 32'd1});
`endif
      exp.push_back('{32'h20, 32'd2});
      chk_log("t5_log", exp);

      // Two stores to one address behind a head that is already on the port.
      memWriteAck = 1'b0;
      wlog.delete();
      push_set(32'h30, 32'd9);
      step();
      commitWriteEnable = 1'b0;
      step();
      push_set(32'h40, 32'd1);
      step();
      push_set(32'h40, 32'd3);
      step();
      commitWriteEnable = 1'b0;
`ifdef WB_COALESCE_EN
      #3 chk("t6_count", 32'(bufCount), 32'd2);
`else
      #3 chk("t6_count", 32'(bufCount), 32'd3);
`endif
      step();
      memWriteAck = 1'b1;
      wait_drained(20);
      exp.delete();
      exp.push_back('{32'h30, 32'd9});
`ifndef WB_COALESCE_EN
      exp.push_back('{32'h40, 32'd1});
`endif
      exp.push_back('{32'h40, 32'd3});
      chk_log("t6_log", exp);

      // Asynchronous reset mid-cycle while a write is outstanding.
      memWriteAck = 1'b0;
      wlog.delete();
      loadQueryAddr = 32'h50;
      push_set(32'h50, 32'd7);
      step();
      commitWriteEnable = 1'b0;
      step();
      #3 chk("t1_mwe_before", 32'(memWriteEnable), 32'd1);
      rst = 1'b1;
      #1 chk("t1_mwe", 32'(memWriteEnable), 32'd0);
      chk("t1_count", 32'(bufCount), 32'd0);
      chk("t1_ready", 32'(commitReady), 32'd1);
      chk("t1_drained", 32'(drained), 32'd1);
      chk("t1_hit", 32'(loadHit), 32'd0);
      chk("t1_addr", memWriteAddr, 32'd0);
      step();
      rst = 1'b0;
      memWriteAck = 1'b1;
      step();
      step();
      #3 chk("t1_lost", 32'(wlog.size()), 32'd0);
      chk("t1_idle", 32'(memWriteEnable), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
